in_port_mc: RTL and testbench

//  Parametrised multi-channel input port between the interconnect and the core.

---
 rtl/in_port_pkg.sv | 33 +++
 rtl/in_port_mc_if.sv | 26 ++
 rtl/in_port_chan_fifo.sv | 46 ++++
 rtl/in_port_mc.sv | 116 +++++++++++
 tb/tb_in_port_mc.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/in_port_pkg.sv
// Shared definitions for the multi-channel input port: idle address, parameter
// legality checks, clog2 helper and the per-channel FIFO status record.
package in_port_pkg;

  localparam int STAT_CNT_W = 16;

  // Wide all-ones constant; each user slices it to its own address width.
  localparam logic [15:0] IDLE_ADDR = '1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit chan_ok(input int num_ch, input int ch_aw);
    return (num_ch >= 1) && (ch_aw <= 16) && (num_ch <= (1 << ch_aw) - 1);
  endfunction

  typedef struct packed {
    logic [STAT_CNT_W-1:0] count;
    logic                  full;
    logic                  empty;
  } chan_status_t;

endpackage

// File: rtl/in_port_mc_if.sv
// Interconnect/core-facing signal bundle of the multi-channel input port.
interface in_port_mc_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3,
  parameter int CH_AW  = 2
);
  logic [CH_AW-1:0]  i_addr;
  logic [DATA_W:0]   data_in;
  logic              valid_back;
  logic [CH_AW-1:0]  c_addr;
  logic              c_read;
  logic [DATA_W-1:0] c_data;
  logic              c_err;
  logic [NUM_CH-1:0] ready;
  logic [15:0]       ovf_cnt;

  modport master (
    output i_addr, data_in, c_addr, c_read,
    input  valid_back, c_data, c_err, ready, ovf_cnt
  );

  modport slave (
    input  i_addr, data_in, c_addr, c_read,
    output valid_back, c_data, c_err, ready, ovf_cnt
  );
endinterface

// File: rtl/in_port_chan_fifo.sv
// Single-channel FIFO: DEPTH entries, pointers wrap naturally (DEPTH is a power of two).
module in_port_chan_fifo
  import in_port_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              gclock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output chan_status_t      status
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  always_ff @(posedge gclock) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge gclock) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  assign dout         = mem[rd_ptr_reg];
  assign status.count = STAT_CNT_W'(count_reg);
  assign status.full  = (count_reg == CW'(DEPTH));
  assign status.empty = (count_reg == '0);

endmodule

// File: rtl/in_port_mc.sv
// Multi-channel input port: per-channel FIFOs between interconnect and core.
// Optional rejected-write counter enabled by defining IN_PORT_OVF_CNT_EN.
module in_port_mc
  import in_port_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3,
  parameter int CH_AW  = 2,
  parameter int DEPTH  = 2
) (
  input  logic    gclock,
  input  logic    reset,
  in_port_mc_if.slave bus
);
  localparam logic [CH_AW-1:0] IDLE     = IDLE_ADDR[CH_AW-1:0];
  localparam logic [CH_AW-1:0] NUM_CH_A = CH_AW'(NUM_CH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("in_port_mc: DEPTH must be a power of two >= 2");
  end
  if (!chan_ok(NUM_CH, CH_AW)) begin : g_bad_chan
    $error("in_port_mc: NUM_CH must be <= 2**CH_AW-1");
  end

  chan_status_t            st        [NUM_CH];
  logic [DATA_W-1:0]       fifo_dout [NUM_CH];
  logic [STAT_CNT_W-1:0]   nxt_cnt   [NUM_CH];
  logic [NUM_CH-1:0]       push;
  logic [NUM_CH-1:0]       pop;
  logic [NUM_CH-1:0]       ready_next;
  logic                    wr;
  logic                    rd_req;
  logic                    pop_any;
  logic                    valid_back_next;
  logic                    c_err_next;
  logic [DATA_W-1:0]       c_data_next;
  logic [DATA_W-1:0]       head;

  logic                    valid_back_reg;
  logic                    c_err_reg;
  logic [DATA_W-1:0]       c_data_reg;
  logic [NUM_CH-1:0]       ready_reg;

  assign wr     = bus.data_in[DATA_W] && (bus.i_addr != IDLE) && (bus.i_addr < NUM_CH_A);
  assign rd_req = bus.c_read && (bus.c_addr < NUM_CH_A);

  // Full/empty are judged on the pre-edge state, so a full channel cannot
  // reuse the slot freed by a same-cycle read and an empty one cannot bypass.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    assign push[gi]       = wr && (bus.i_addr == CH_AW'(gi)) && !st[gi].full;
    assign pop[gi]        = rd_req && (bus.c_addr == CH_AW'(gi)) && !st[gi].empty;
    assign nxt_cnt[gi]    = st[gi].count + STAT_CNT_W'(push[gi]) - STAT_CNT_W'(pop[gi]);
    assign ready_next[gi] = (nxt_cnt[gi] != '0);

    in_port_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .gclock (gclock),
      .reset  (reset),
      .push   (push[gi]),
      .pop    (pop[gi]),
      .din    (bus.data_in[DATA_W-1:0]),
      .dout   (fifo_dout[gi]),
      .status (st[gi])
    );
  end

  always_comb begin
    head = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (pop[n]) head = fifo_dout[n];
    end
  end

  assign pop_any         = |pop;
  assign valid_back_next = wr && !(|push);
  assign c_data_next     = pop_any ? head : c_data_reg;
  assign c_err_next      = bus.c_read ? !pop_any : c_err_reg;

  always_ff @(posedge gclock) begin
    if (!reset) begin
      valid_back_reg <= 1'b0;
      c_err_reg      <= 1'b0;
      c_data_reg     <= '0;
      ready_reg      <= '0;
    end else begin
      valid_back_reg <= valid_back_next;
      c_err_reg      <= c_err_next;
      c_data_reg     <= c_data_next;
      ready_reg      <= ready_next;
    end
  end

  assign bus.valid_back = valid_back_reg;
  assign bus.c_err      = c_err_reg;
  assign bus.c_data     = c_data_reg;
  assign bus.ready      = ready_reg;

`ifdef IN_PORT_OVF_CNT_EN
  logic [15:0] ovf_cnt_reg;

  always_ff @(posedge gclock) begin
    if (!reset) begin
      ovf_cnt_reg <= '0;
    end else if (valid_back_next && (ovf_cnt_reg != 16'hFFFF)) begin
      ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_reg;
`else
  assign bus.ovf_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_in_port_mc.sv
// Randomised + directed bench for in_port_mc with a queue-based reference model
// and a scoreboard monitor decoupled from the stimulus driver.
module tb_in_port_mc;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 3;
  localparam int CH_AW  = 2;
  localparam int DEPTH  = 2;

  typedef struct {
    int          cyc;
    logic        vb;
    logic [31:0] cd;
    logic        ce;
    logic [2:0]  rdy;
    logic [15:0] ovf;
  } exp_t;

  logic gclock;
  logic reset;
  int   checks;
  int   failures;
  int   cyc_no;
  exp_t exp_q[$];

  logic [31:0] mq [NUM_CH][$];
  logic        m_vb;
  logic [31:0] m_cd;
  logic        m_ce;
  logic [15:0] m_ovf;

  in_port_mc_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_AW(CH_AW)) bus ();

  in_port_mc #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .CH_AW  (CH_AW),
    .DEPTH  (DEPTH)
  ) dut (
    .gclock (gclock),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial gclock = 1'b0;
  always #5 gclock = ~gclock;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: FIFO semantics applied directly to per-channel queues.
  task automatic model_step(input bit rn, input logic [1:0] ia, input bit dv,
                            input logic [31:0] pl, input logic [1:0] ca, input bit rd);
    bit   wr;
    bit   wr_ok;
    bit   rd_ok;
    exp_t e;
    if (!rn) begin
      for (int n = 0; n < NUM_CH; n++) mq[n].delete();
      m_vb = 0; m_cd = '0; m_ce = 0; m_ovf = '0;
    end else begin
      wr    = dv && (ia != 2'b11) && (int'(ia) < NUM_CH);
      wr_ok = wr && (mq[ia].size() < DEPTH);
      rd_ok = rd && (int'(ca) < NUM_CH) && (mq[ca].size() > 0);
      if (rd) begin
        if (rd_ok) begin
          m_cd = mq[ca].pop_front();
          m_ce = 0;
        end else begin
          m_ce = 1;
        end
      end
      if (wr_ok) mq[ia].push_back(pl);
      m_vb = wr && !wr_ok;
      if (m_vb && m_ovf != 16'hFFFF) m_ovf++;
    end
    e.cyc = cyc_no;
    e.vb  = m_vb;
    e.cd  = m_cd;
    e.ce  = m_ce;
    for (int n = 0; n < NUM_CH; n++) e.rdy[n] = (mq[n].size() != 0);
`ifdef IN_PORT_OVF_CNT_EN
    e.ovf = m_ovf;
`else
    e.ovf = 16'h0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rn, input logic [1:0] ia, input bit dv,
                     input logic [31:0] pl, input logic [1:0] ca, input bit rd);
    @(negedge gclock);
    cyc_no++;
    reset       = rn;
    bus.i_addr  = ia;
    bus.data_in = {dv, pl};
    bus.c_addr  = ca;
    bus.c_read  = rd;
    model_step(rn, ia, dv, pl, ca, rd);
  endtask

  task automatic idle();
    cyc(1, 2'b11, 0, '0, 2'b00, 0);
  endtask

  // Monitor: registered outputs settle right after the edge that follows each stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge gclock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_back", e.cyc, 32'(bus.valid_back), 32'(e.vb));
        chk("c_data",     e.cyc, bus.c_data,          e.cd);
        chk("c_err",      e.cyc, 32'(bus.c_err),      32'(e.ce));
        chk("ready",      e.cyc, 32'(bus.ready),      32'(e.rdy));
        chk("ovf_cnt",    e.cyc, 32'(bus.ovf_cnt),    32'(e.ovf));
        $display("cyc %0d: vb=%0b c_data=%h c_err=%0b ready=%b ovf=%0d",
                 e.cyc, bus.valid_back, bus.c_data, bus.c_err, bus.ready, bus.ovf_cnt);
      end
    end
  end

  initial begin
    int wait_cyc;
    checks = 0; failures = 0; cyc_no = 0;
    reset = 1'b0;
    bus.i_addr = 2'b11; bus.data_in = '0; bus.c_addr = '0; bus.c_read = 1'b0;

    repeat (3) cyc(0, 2'b11, 0, '0, 2'b00, 0);

    // Traffic, then a single-cycle reset pulse mid-transfer.
    for (int i = 0; i < 12; i++)
      cyc(1, 2'($urandom_range(0, 2)), 1, $urandom, 2'($urandom_range(0, 2)), 1'($urandom));
    cyc(0, 2'b00, 1, 32'hDEAD_0001, 2'b01, 1);
    idle();

    // Fill channel 1 past capacity, then drain it and read once more.
    cyc(1, 2'b01, 1, 32'hA1, 2'b00, 0);
    cyc(1, 2'b01, 1, 32'hA2, 2'b00, 0);
    cyc(1, 2'b01, 1, 32'hA3, 2'b00, 0);
    idle();
    repeat (3) cyc(1, 2'b11, 0, '0, 2'b01, 1);
    idle();

    // Full channel 0 with simultaneous read and write.
    cyc(1, 2'b00, 1, 32'hB1, 2'b00, 0);
    cyc(1, 2'b00, 1, 32'hB2, 2'b00, 0);
    cyc(1, 2'b00, 1, 32'hB3, 2'b00, 1);
    cyc(1, 2'b11, 0, '0, 2'b00, 1);
    cyc(1, 2'b11, 0, '0, 2'b00, 1);
    // Empty channel with simultaneous read and write: no bypass.
    cyc(1, 2'b00, 1, 32'hB4, 2'b00, 1);
    cyc(1, 2'b11, 0, '0, 2'b00, 1);

    // Idle address with word-valid set, and a read of the idle address.
    cyc(1, 2'b11, 1, 32'hC1, 2'b11, 0);
    cyc(1, 2'b11, 1, 32'hC2, 2'b11, 1);

    // Five rejected writes on a full channel 2.
    cyc(1, 2'b10, 1, 32'hD1, 2'b00, 0);
    cyc(1, 2'b10, 1, 32'hD2, 2'b00, 0);
    repeat (5) cyc(1, 2'b10, 1, $urandom, 2'b00, 0);
    idle();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) != 0), 2'($urandom), 1'($urandom_range(0, 3) != 0),
          $urandom, 2'($urandom), 1'($urandom_range(0, 2) != 0));
    idle();

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge gclock);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
